dmem_ctrl: RTL and testbench

//  Parametrised data memory for the pipelined core, fronted by a valid/ready request and response handshake.

---
 rtl/dmem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data memory behind the MEM stage: valid/ready request and response,
// byte-lane stores, sign/zero-extended loads, programmable read latency.
module dmem_ctrl #(
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic enter_resp;
  logic leave_resp;

  logic          we_q;
  logic [2:0]    type_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    err_q;

  logic [31:0] rdata_q, rdata_n;
  logic [1:0]  rerr_q;

  logic [31:0] mem [DEPTH];

  logic       accept;
  logic       illegal, misal, oor;
  logic [1:0] err_now;
  logic [3:0] be;
  logic [31:0] wd;
  logic       wr_fire;

  logic          rd_we;
  logic [2:0]    rd_type;
  logic [AW+1:0] rd_addr;
  logic [1:0]    rd_err;
  logic [31:0]   word;
  logic [15:0]   half;
  logic [7:0]    byte_v;
  logic [31:0]   load_val;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;
  assign accept     = req_valid & req_ready;

  // Error priority: illegal type, then misaligned, then out of range.
  always_comb begin
    illegal = (req_type > 3'd4);
    misal   = 1'b0;
    case (req_type)
      3'd0:       misal = |req_addr[1:0];
      3'd1, 3'd2: misal = req_addr[0];
      default:    misal = 1'b0;
    endcase
    oor = ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    if (illegal)     err_now = 2'b11;
    else if (misal)  err_now = 2'b01;
    else if (oor)    err_now = 2'b10;
    else             err_now = 2'b00;
  end

  always_comb begin
    be = 4'h0;
    wd = 32'h0;
    case (req_type)
      3'd0: begin
        be = 4'hF;
        wd = req_wdata;
      end
      3'd1, 3'd2: begin
        be = req_addr[1] ? 4'hC : 4'h3;
        wd = {2{req_wdata[15:0]}};
      end
      3'd3, 3'd4: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      default: begin
        be = 4'h0;
        wd = 32'h0;
      end
    endcase
  end

  assign wr_fire = accept & req_we & (err_now == 2'b00) & ~reset;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[req_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // With READ_LAT==1 the response is built straight from the request.
  always_comb begin
    if (state == IDLE) begin
      rd_we   = req_we;
      rd_type = req_type;
      rd_addr = req_addr[AW+1:0];
      rd_err  = err_now;
    end else begin
      rd_we   = we_q;
      rd_type = type_q;
      rd_addr = addr_q;
      rd_err  = err_q;
    end
  end

  always_comb begin
    word     = mem[rd_addr[AW+1:2]];
    half     = rd_addr[1] ? word[31:16] : word[15:0];
    byte_v   = word[{rd_addr[1:0], 3'b000} +: 8];
    load_val = 32'h0;
    case (rd_type)
      3'd0:    load_val = word;
      3'd1:    load_val = {{16{half[15]}}, half};
      3'd2:    load_val = {16'h0, half};
      3'd3:    load_val = {{24{byte_v[7]}}, byte_v};
      3'd4:    load_val = {24'h0, byte_v};
      default: load_val = 32'h0;
    endcase
    if (rd_we || (rd_err != 2'b00)) rdata_n = 32'h0;
    else                            rdata_n = load_val;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    leave_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (READ_LAT == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = 3'(READ_LAT - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n    = IDLE;
          leave_resp = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      we_q    <= 1'b0;
      type_q  <= 3'd0;
      addr_q  <= '0;
      err_q   <= 2'b00;
      rdata_q <= 32'h0;
      rerr_q  <= 2'b00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        we_q   <= req_we;
        type_q <= req_type;
        addr_q <= req_addr[AW+1:0];
        err_q  <= err_now;
      end
      if (enter_resp) begin
        rdata_q <= rdata_n;
        rerr_q  <= rd_err;
      end else if (leave_resp) begin
        rdata_q <= 32'h0;
        rerr_q  <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: latency 1 function checks, latency 3
// back-pressure hold, latency 4 reset abort.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rst1, v1, rdy1, vo1, rr1;
  logic [31:0] rd1;
  logic [1:0]  er1;
  logic        rst3, v3, rdy3, vo3, rr3;
  logic [31:0] rd3;
  logic [1:0]  er3;
  logic        rst4, v4, rdy4, vo4, rr4;
  logic [31:0] rd4;
  logic [1:0]  er4;

  int total = 0;
  int bad   = 0;

  dmem_ctrl #(.DEPTH(128), .READ_LAT(1)) u1 (
    .clk(clk), .reset(rst1),
    .req_valid(v1), .req_ready(rdy1),
    .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vo1), .resp_ready(rr1),
    .resp_rdata(rd1), .resp_err(er1)
  );

  dmem_ctrl #(.DEPTH(128), .READ_LAT(3)) u3 (
    .clk(clk), .reset(rst3),
    .req_valid(v3), .req_ready(rdy3),
    .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vo3), .resp_ready(rr3),
    .resp_rdata(rd3), .resp_err(er3)
  );

  dmem_ctrl #(.DEPTH(128), .READ_LAT(4)) u4 (
    .clk(clk), .reset(rst4),
    .req_valid(v4), .req_ready(rdy4),
    .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vo4), .resp_ready(rr4),
    .resp_rdata(rd4), .resp_err(er4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] ty,
                       input logic [31:0] a, input logic [31:0] d);
    req_we    = we;
    req_type  = ty;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic xfer1(input string tag, input logic we,
                       input logic [2:0] ty, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d,
                       input logic [1:0] exp_e);
    drive(we, ty, a, d);
    v1 = 1'b1;
    chk({tag, ".req_ready"}, {31'b0, rdy1}, 32'd1);
    step();
    v1 = 1'b0;
    chk({tag, ".resp_valid"}, {31'b0, vo1}, 32'd1);
    chk({tag, ".rdata"}, rd1, exp_d);
    chk({tag, ".err"}, {30'b0, er1}, {30'b0, exp_e});
    rr1 = 1'b1;
    step();
    rr1 = 1'b0;
    chk({tag, ".idle"}, {31'b0, rdy1}, 32'd1);
  endtask

  logic [31:0] held;

  initial begin
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    {v1, v3, v4} = 3'b000;
    {rr1, rr3, rr4} = 3'b000;
    {rst1, rst3, rst4} = 3'b111;
    step();
    step();
    chk("rst.valid1", {31'b0, vo1}, 32'd0);
    chk("rst.rdata1", rd1, 32'h0);
    chk("rst.err1", {30'b0, er1}, 32'd0);
    chk("rst.ready1", {31'b0, rdy1}, 32'd1);
    chk("rst.valid3", {31'b0, vo3}, 32'd0);
    chk("rst.ready4", {31'b0, rdy4}, 32'd1);
    {rst1, rst3, rst4} = 3'b000;
    step();

    xfer1("sw10", 1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00);
    xfer1("lw10", 1'b0, 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
    xfer1("sb13", 1'b1, 3'd3, 32'h13, 32'h80, 32'h0, 2'b00);
    xfer1("lb13", 1'b0, 3'd3, 32'h13, 32'h0, 32'hFFFFFF80, 2'b00);
    xfer1("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000080, 2'b00);
    xfer1("lw10b", 1'b0, 3'd0, 32'h10, 32'h0, 32'h80ADBEEF, 2'b00);
    xfer1("lhu12", 1'b0, 3'd2, 32'h12, 32'h0, 32'h000080AD, 2'b00);
    xfer1("lh12", 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF80AD, 2'b00);
    xfer1("lh10", 1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 2'b00);
    xfer1("lw12", 1'b0, 3'd0, 32'h12, 32'h0, 32'h0, 2'b01);
    xfer1("sh11", 1'b1, 3'd1, 32'h11, 32'h1234, 32'h0, 2'b01);
    xfer1("lw10c", 1'b0, 3'd0, 32'h10, 32'h0, 32'h80ADBEEF, 2'b00);
    xfer1("lw200", 1'b0, 3'd0, 32'h200, 32'h0, 32'h0, 2'b10);
    xfer1("ill201", 1'b0, 3'd5, 32'h201, 32'h0, 32'h0, 2'b11);
    xfer1("illst", 1'b1, 3'd7, 32'h10, 32'h55555555, 32'h0, 2'b11);
    xfer1("lw10d", 1'b0, 3'd0, 32'h10, 32'h0, 32'h80ADBEEF, 2'b00);
    xfer1("sw1fc", 1'b1, 3'd0, 32'h1FC, 32'h11223344, 32'h0, 2'b00);
    xfer1("lb1fd", 1'b0, 3'd3, 32'h1FD, 32'h0, 32'h00000033, 2'b00);
    xfer1("lh1fe", 1'b0, 3'd1, 32'h1FE, 32'h0, 32'h00001122, 2'b00);
    xfer1("sb200", 1'b1, 3'd3, 32'h200, 32'hAA, 32'h0, 2'b10);

    // Latency 3 with a 5-cycle consumer stall.
    drive(1'b1, 3'd0, 32'h20, 32'hCAFEF00D);
    v3 = 1'b1;
    step();
    v3 = 1'b0;
    chk("l3.sw.e1", {31'b0, vo3}, 32'd0);
    step();
    chk("l3.sw.e2", {31'b0, vo3}, 32'd0);
    step();
    chk("l3.sw.e3", {31'b0, vo3}, 32'd1);
    chk("l3.sw.rdata", rd3, 32'h0);
    rr3 = 1'b1;
    step();
    rr3 = 1'b0;
    chk("l3.sw.idle", {31'b0, rdy3}, 32'd1);

    drive(1'b0, 3'd1, 32'h22, 32'h0);
    v3 = 1'b1;
    step();
    v3 = 1'b0;
    drive(1'b1, 3'd0, 32'h0, 32'hFFFFFFFF);
    chk("l3.lh.e1", {31'b0, vo3}, 32'd0);
    step();
    chk("l3.lh.e2", {31'b0, vo3}, 32'd0);
    step();
    chk("l3.lh.e3", {31'b0, vo3}, 32'd1);
    chk("l3.lh.rdata", rd3, 32'hFFFFCAFE);
    chk("l3.lh.err", {30'b0, er3}, 32'd0);
    held = rd3;
    v3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("l3.hold.valid", {31'b0, vo3}, 32'd1);
      chk("l3.hold.rdata", rd3, held);
      chk("l3.hold.ready", {31'b0, rdy3}, 32'd0);
    end
    v3 = 1'b0;
    rr3 = 1'b1;
    step();
    rr3 = 1'b0;
    chk("l3.done.valid", {31'b0, vo3}, 32'd0);
    chk("l3.done.ready", {31'b0, rdy3}, 32'd1);
    chk("l3.done.rdata", rd3, 32'h0);

    // Latency 4, reset one cycle after accepting a load.
    drive(1'b0, 3'd0, 32'h20, 32'h0);
    v4 = 1'b1;
    step();
    v4 = 1'b0;
    chk("l4.acc.ready", {31'b0, rdy4}, 32'd0);
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    chk("l4.rst.valid", {31'b0, vo4}, 32'd0);
    chk("l4.rst.ready", {31'b0, rdy4}, 32'd1);
    rr4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("l4.quiet.valid", {31'b0, vo4}, 32'd0);
      chk("l4.quiet.rdata", rd4, 32'h0);
    end
    rr4 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
